// File: rtl/dmem_port_ctrl.sv
// Two-port access controller for the byte-lane data memory: round-robin arbitration,
// one-cycle access sequencing, store lane steering and load alignment/extension.
module dmem_port_ctrl #(
    parameter int unsigned DMEM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rq0_valid,
    output logic        rq0_ready,
    input  logic        rq0_we,
    input  logic [31:0] rq0_addr,
    input  logic [1:0]  rq0_size,
    input  logic        rq0_unsigned,
    input  logic [31:0] rq0_wdata,
    input  logic        rq1_valid,
    output logic        rq1_ready,
    input  logic        rq1_we,
    input  logic [31:0] rq1_addr,
    input  logic [1:0]  rq1_size,
    input  logic        rq1_unsigned,
    input  logic [31:0] rq1_wdata,
    output logic        rs0_valid,
    output logic [31:0] rs0_rdata,
    output logic        rs0_err,
    output logic        rs1_valid,
    output logic [31:0] rs1_rdata,
    output logic        rs1_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    input  logic [31:0] drdata,
    output logic        fsm_state
);

    // Handshake: a request transfers on the cycle where rqN_valid & rqN_ready are both
    // high; the requester holds its fields stable until then, and they are latched only then.
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(DMEM_BYTES);

    state_t      state, state_nxt;
    logic        last_grant;
    logic        grant;
    logic        accept;
    logic        in_access;
    logic        illegal;
    logic        l_port;
    logic        l_we;
    logic        l_uns;
    logic [31:0] l_addr;
    logic [1:0]  l_size;
    logic [31:0] l_wdata;
    logic [3:0]  lane_we;
    logic [31:0] lane_data;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] rsp_data;

    // Round-robin only matters on a tie; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (rq0_valid && rq1_valid) begin
            grant = ~last_grant;
        end else if (rq1_valid) begin
            grant = 1'b1;
        end
    end

    assign rq0_ready = (state == IDLE) && rq0_valid && !grant;
    assign rq1_ready = (state == IDLE) && rq1_valid && grant;
    assign accept    = rq0_ready || rq1_ready;
    assign in_access = (state == ACCESS);
    assign fsm_state = in_access;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            l_port     <= 1'b0;
            l_we       <= 1'b0;
            l_uns      <= 1'b0;
            l_addr     <= '0;
            l_size     <= '0;
            l_wdata    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= grant;
                l_port     <= grant;
                l_we       <= grant ? rq1_we       : rq0_we;
                l_uns      <= grant ? rq1_unsigned : rq0_unsigned;
                l_addr     <= grant ? rq1_addr     : rq0_addr;
                l_size     <= grant ? rq1_size     : rq0_size;
                l_wdata    <= grant ? rq1_wdata    : rq0_wdata;
            end
        end
    end

    always_comb begin
        illegal = 1'b0;
        case (l_size)
            2'b01:   illegal = l_addr[0];
            2'b10:   illegal = |l_addr[1:0];
            2'b11:   illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
        if (l_addr >= ADDR_LIMIT) illegal = 1'b1;
    end

    // Store data is replicated across lanes so the enable alone picks the target bytes.
    always_comb begin
        lane_we   = 4'b0000;
        lane_data = l_wdata;
        case (l_size)
            2'b00: begin
                lane_we   = 4'b0001 << l_addr[1:0];
                lane_data = {4{l_wdata[7:0]}};
            end
            2'b01: begin
                lane_we   = l_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{l_wdata[15:0]}};
            end
            2'b10:   lane_we = 4'b1111;
            default: lane_we = 4'b0000;
        endcase
    end

    assign daddr  = in_access ? {l_addr[31:2], 2'b00} : 32'h0;
    assign dwdata = in_access ? lane_data : 32'h0;
    assign dwe    = (in_access && l_we && !illegal) ? lane_we : 4'b0000;

    always_comb begin
        shifted   = drdata >> {l_addr[1:0], 3'b000};
        load_data = shifted;
        case (l_size)
            2'b00:   load_data = l_uns ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = l_uns ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
        rsp_data = (illegal || l_we) ? 32'h0 : load_data;
    end

    // Responses go only to the port whose request is in flight; the other stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs0_valid <= 1'b0;
            rs0_rdata <= '0;
            rs0_err   <= 1'b0;
            rs1_valid <= 1'b0;
            rs1_rdata <= '0;
            rs1_err   <= 1'b0;
        end else begin
            rs0_valid <= in_access && !l_port;
            rs0_rdata <= (in_access && !l_port) ? rsp_data : 32'h0;
            rs0_err   <= in_access && !l_port && illegal;
            rs1_valid <= in_access && l_port;
            rs1_rdata <= (in_access && l_port) ? rsp_data : 32'h0;
            rs1_err   <= in_access && l_port && illegal;
        end
    end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Bench for dmem_port_ctrl: directed and random requests on both ports, checked against a
// byte-array memory model with a per-port expected-response queue.
module tb_dmem_port_ctrl;

    localparam int DMEM_BYTES = 16384;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rq0_valid, rq0_ready, rq0_we, rq0_unsigned;
    logic [31:0] rq0_addr, rq0_wdata;
    logic [1:0]  rq0_size;
    logic        rq1_valid, rq1_ready, rq1_we, rq1_unsigned;
    logic [31:0] rq1_addr, rq1_wdata;
    logic [1:0]  rq1_size;
    logic        rs0_valid, rs0_err, rs1_valid, rs1_err;
    logic [31:0] rs0_rdata, rs1_rdata;
    logic [31:0] daddr, dwdata, drdata;
    logic [3:0]  dwe;
    logic        fsm_state;

    always #5 clk = ~clk;

    dmem_port_ctrl #(.DMEM_BYTES(DMEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_we(rq0_we), .rq0_addr(rq0_addr),
        .rq0_size(rq0_size), .rq0_unsigned(rq0_unsigned), .rq0_wdata(rq0_wdata),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_we(rq1_we), .rq1_addr(rq1_addr),
        .rq1_size(rq1_size), .rq1_unsigned(rq1_unsigned), .rq1_wdata(rq1_wdata),
        .rs0_valid(rs0_valid), .rs0_rdata(rs0_rdata), .rs0_err(rs0_err),
        .rs1_valid(rs1_valid), .rs1_rdata(rs1_rdata), .rs1_err(rs1_err),
        .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata), .fsm_state(fsm_state)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } req_t;

    req_t        pend0[$], pend1[$];
    logic [32:0] exp_q0[$], exp_q1[$];
    logic [31:0] hw_mem [0:4095];
    logic [7:0]  ref_mem [0:DMEM_BYTES-1];
    int          n_checks, n_errors, cyc, next_ok, last_port, act_port;
    bit          act_valid, rand_mode;
    req_t        act;
    logic [3:0]  s_we;
    logic [31:0] s_addr, s_data;

    assign drdata = hw_mem[daddr[13:2]];

    task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic req_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.size = size; r.uns = uns; r.wdata = wdata;
        return r;
    endfunction

    function automatic bit is_legal(input req_t r);
        if (r.size == 2'b11) return 1'b0;
        if (r.size == 2'b01 && (r.addr % 2) != 0) return 1'b0;
        if (r.size == 2'b10 && (r.addr % 4) != 0) return 1'b0;
        return r.addr < DMEM_BYTES;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   k;
        k       = $urandom_range(0, 19);
        r.we    = 1'($urandom_range(0, 1));
        r.uns   = 1'($urandom_range(0, 1));
        r.wdata = $urandom;
        r.size  = (k == 19) ? 2'b11 : 2'(k % 3);
        r.addr  = (($urandom_range(0, 3) == 0) ? 32'd16320 : 32'd0) + 32'($urandom_range(0, 63));
        if ($urandom_range(0, 4) != 0) r.addr = r.addr & ~((32'd1 << r.size) - 32'd1);
        if ($urandom_range(0, 15) == 0)
            r.addr = 32'(DMEM_BYTES) + (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom);
        return r;
    endfunction

    // Reference behaviour of one completed access: update the byte array, queue the response.
    task automatic model_complete();
        logic [31:0] v;
        int          n;
        v = 32'h0;
        n = 1 << act.size;
        if (!is_legal(act)) begin
            v = 32'h0;
            if (act_port == 0) exp_q0.push_back({1'b1, v}); else exp_q1.push_back({1'b1, v});
        end else begin
            if (act.we) begin
                for (int i = 0; i < n; i++) ref_mem[act.addr + i] = act.wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[act.addr + i];
                if (!act.uns && n == 1) v = {{24{v[7]}}, v[7:0]};
                if (!act.uns && n == 2) v = {{16{v[15]}}, v[15:0]};
            end
            if (act_port == 0) exp_q0.push_back({1'b0, v}); else exp_q1.push_back({1'b0, v});
        end
    endtask

    task automatic drive_inputs();
        req_t r;
        if (rand_mode) begin
            if (pend0.size() == 0 && $urandom_range(0, 9) < 6) pend0.push_back(rand_req());
            if (pend1.size() == 0 && $urandom_range(0, 9) < 6) pend1.push_back(rand_req());
        end
        rq0_valid = (pend0.size() != 0);
        r = rq0_valid ? pend0[0] : rand_req();
        rq0_we = r.we; rq0_addr = r.addr; rq0_size = r.size; rq0_unsigned = r.uns; rq0_wdata = r.wdata;
        rq1_valid = (pend1.size() != 0);
        r = rq1_valid ? pend1[0] : rand_req();
        rq1_we = r.we; rq1_addr = r.addr; rq1_size = r.size; rq1_unsigned = r.uns; rq1_wdata = r.wdata;
    endtask

    task automatic check_rs();
        logic [32:0] e;
        if (exp_q0.size() != 0) begin
            e = exp_q0.pop_front();
            check_eq("rs0_valid", rs0_valid, 1'b1);
            check_eq("rs0_err", rs0_err, e[32]);
            check_eq("rs0_rdata", rs0_rdata, e[31:0]);
        end else begin
            check_eq("rs0_valid_idle", rs0_valid, 1'b0);
            check_eq("rs0_rdata_idle", {rs0_err, rs0_rdata}, 33'h0);
        end
        if (exp_q1.size() != 0) begin
            e = exp_q1.pop_front();
            check_eq("rs1_valid", rs1_valid, 1'b1);
            check_eq("rs1_err", rs1_err, e[32]);
            check_eq("rs1_rdata", rs1_rdata, e[31:0]);
        end else begin
            check_eq("rs1_valid_idle", rs1_valid, 1'b0);
            check_eq("rs1_rdata_idle", {rs1_err, rs1_rdata}, 33'h0);
        end
    endtask

    task automatic step();
        int          g, n;
        logic [3:0]  e_we;
        logic [31:0] e_wd;
        drive_inputs();
        @(negedge clk);
        g = -1;
        if (cyc >= next_ok) begin
            if (rq0_valid && rq1_valid) g = (last_port == 0) ? 1 : 0;
            else if (rq0_valid) g = 0;
            else if (rq1_valid) g = 1;
        end
        check_eq("rq0_ready", rq0_ready, g == 0);
        check_eq("rq1_ready", rq1_ready, g == 1);
        check_eq("fsm_state", fsm_state, act_valid);
        if (act_valid) begin
            check_eq("daddr", daddr, act.addr & ~32'd3);
            if (is_legal(act) && act.we) begin
                n    = 1 << act.size;
                e_we = 4'b0000;
                for (int i = 0; i < n; i++) e_we[(act.addr + i) % 4] = 1'b1;
                for (int l = 0; l < 4; l++) e_wd[8*l +: 8] = act.wdata[8*(l % n) +: 8];
                check_eq("dwe_store", dwe, e_we);
                check_eq("dwdata_store", dwdata, e_wd);
            end else begin
                check_eq("dwe_no_write", dwe, 4'b0000);
            end
        end else begin
            check_eq("bus_idle", {daddr, dwdata[0], dwe}, 37'h0);
            check_eq("dwdata_idle", dwdata, 32'h0);
        end
        check_rs();
        s_we = dwe; s_addr = daddr; s_data = dwdata;
        @(posedge clk);
        for (int l = 0; l < 4; l++)
            if (s_we[l]) hw_mem[s_addr[13:2]][8*l +: 8] = s_data[8*l +: 8];
        if (act_valid) begin
            model_complete();
            act_valid = 1'b0;
        end
        if (g >= 0) begin
            act       = (g == 0) ? pend0.pop_front() : pend1.pop_front();
            act_port  = g;
            act_valid = 1'b1;
            last_port = g;
            next_ok   = cyc + 2;
        end
        cyc++;
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((pend0.size() != 0 || pend1.size() != 0 || act_valid ||
                exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
            step();
            n++;
        end
        check_eq({tag, "_completed"}, n < 200, 1'b1);
    endtask

    initial begin
        logic [31:0] w;
        int          n;
        n_checks = 0; n_errors = 0; cyc = 0; next_ok = 0; last_port = 1;
        act_valid = 1'b0; rand_mode = 1'b0; act_port = 0;
        for (int i = 0; i < 4096; i++) begin
            w = $urandom;
            hw_mem[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        rst_n = 1'b0;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_rs", {rs0_valid, rs0_err, rs1_valid, rs1_err}, 4'h0);
        check_eq("reset_rdata", {1'b0, rs0_rdata | rs1_rdata}, 33'h0);
        check_eq("reset_bus", {daddr, dwe}, 36'h0);
        check_eq("reset_dwdata", dwdata, 32'h0);
        check_eq("reset_state", fsm_state, 1'b0);
        rq0_valid = 1'b1; rq1_valid = 1'b1;
        #1;
        check_eq("reset_tie_rq0_ready", rq0_ready, 1'b1);
        check_eq("reset_tie_rq1_ready", rq1_ready, 1'b0);
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        #1 rst_n = 1'b1;

        pend0.push_back(mk(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF));
        pend0.push_back(mk(1'b0, 32'h10, 2'b10, 1'b0, 32'h0));
        drain("word_rw");

        pend0.push_back(mk(1'b1, 32'h20, 2'b10, 1'b0, 32'h80FF7F01));
        pend0.push_back(mk(1'b0, 32'h21, 2'b00, 1'b0, 32'h0));
        pend0.push_back(mk(1'b0, 32'h23, 2'b00, 1'b0, 32'h0));
        pend0.push_back(mk(1'b0, 32'h22, 2'b01, 1'b1, 32'h0));
        pend0.push_back(mk(1'b1, 32'h22, 2'b00, 1'b0, 32'h000000AB));
        pend0.push_back(mk(1'b0, 32'h20, 2'b10, 1'b0, 32'h0));
        drain("extend");

        pend1.push_back(mk(1'b1, 32'h21, 2'b01, 1'b0, 32'h1234));
        pend1.push_back(mk(1'b0, 32'h21, 2'b01, 1'b0, 32'h0));
        pend1.push_back(mk(1'b0, 32'h4000, 2'b10, 1'b0, 32'h0));
        pend1.push_back(mk(1'b1, 32'h3FFC, 2'b10, 1'b0, 32'hCAFEF00D));
        pend1.push_back(mk(1'b1, 32'h24, 2'b11, 1'b0, 32'hFFFFFFFF));
        pend1.push_back(mk(1'b0, 32'h20, 2'b10, 1'b0, 32'h0));
        drain("errors");

        for (int i = 0; i < 4; i++) begin
            pend0.push_back(mk(1'b1, 32'(64 + 4*i), 2'b10, 1'b0, $urandom));
            pend1.push_back(mk(1'b0, 32'(64 + 4*i), 2'b10, 1'b0, 32'h0));
        end
        drain("arbitration");

        for (int i = 0; i < 4; i++) pend1.push_back(mk(1'b0, 32'(2*i), 2'b01, 1'b0, 32'h0));
        drain("port1_alone");

        rand_mode = 1'b1;
        repeat (1500) step();
        rand_mode = 1'b0;
        drain("random");

        pend0.push_back(mk(1'b1, 32'h30, 2'b00, 1'b0, {24'h0, ~ref_mem[48]}));
        n = 0;
        while (!act_valid && n < 20) begin
            step();
            n++;
        end
        check_eq("reset_test_accept", act_valid, 1'b1);
        drive_inputs();
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_reset_dwe", dwe, 4'b0000);
        check_eq("mid_reset_daddr", daddr, 32'h0);
        check_eq("mid_reset_state", fsm_state, 1'b0);
        @(negedge clk);
        s_we = dwe; s_addr = daddr; s_data = dwdata;
        @(posedge clk);
        for (int l = 0; l < 4; l++)
            if (s_we[l]) hw_mem[s_addr[13:2]][8*l +: 8] = s_data[8*l +: 8];
        cyc++;
        #1;
        check_eq("mid_reset_mem", hw_mem[12][7:0], ref_mem[48]);
        check_eq("mid_reset_rs", {rs0_valid, rs1_valid}, 2'b00);
        rst_n = 1'b1;
        act_valid = 1'b0; last_port = 1; next_ok = cyc;
        exp_q0.delete(); exp_q1.delete();
        pend0.push_back(mk(1'b0, 32'h30, 2'b00, 1'b1, 32'h0));
        pend1.push_back(mk(1'b0, 32'h30, 2'b10, 1'b0, 32'h0));
        drain("after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
